// File: rtl/sequence_presenter.sv
// sequence_presenter: generates a four-digit LFSR challenge and presents it digit by digit on a tick schedule.
module sequence_presenter #(
    parameter int         TICK_DIV   = 3500000,
    parameter int         SHOW_TICKS = 4,
    parameter int         GAP_TICKS  = 1,
    parameter logic [7:0] SEED       = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [3:0]  digit,
    output logic        digit_valid,
    output logic [1:0]  digit_idx,
    output logic [15:0] seq,
    output logic        busy,
    output logic        done
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int TW = $clog2((SHOW_TICKS > GAP_TICKS ? SHOW_TICKS : GAP_TICKS) + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHOW, GAP, DONE} state_t;

    state_t        state, state_n;
    logic [7:0]    lfsr;
    logic          start_d;
    logic [CW-1:0] cnt;
    logic [TW-1:0] ticks;
    logic [1:0]    idx_n;
    logic [3:0]    mapped;
    logic          rise, tick;

    always_comb begin
        rise    = start && !start_d;
        tick    = cnt == CNT_LAST;
        mapped  = lfsr[3:0] > 4'd9 ? lfsr[3:0] - 4'd10 : lfsr[3:0];
        state_n = state;
        case (state)
            IDLE, DONE: state_n = rise ? LOAD : state;
            LOAD:       state_n = digit_idx == 2'd3 ? SHOW : LOAD;
            SHOW:       state_n = tick && ticks == SHOW_LAST ? GAP : SHOW;
            GAP:        state_n = tick && ticks == GAP_LAST ? (digit_idx == 2'd3 ? DONE : SHOW) : GAP;
            default:    state_n = IDLE;
        endcase
        // digit_idx doubles as the LOAD slot pointer; it wraps 3->0 exactly when SHOW begins
        idx_n = (state_n == LOAD && state != LOAD) ? 2'd0 :
                (state == LOAD || (state == GAP && state_n == SHOW)) ? digit_idx + 2'd1 : digit_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lfsr        <= SEED;
            start_d     <= 1'b0;
            cnt         <= '0;
            ticks       <= '0;
            seq         <= '0;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            digit_idx   <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            lfsr        <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            start_d     <= start;
            cnt         <= (state_n != state || tick) ? '0 : cnt + 1'b1;
            ticks       <= state_n != state ? '0 : ticks + TW'(tick);
            if (state == LOAD) seq[{digit_idx, 2'b00} +: 4] <= mapped;
            digit_idx   <= idx_n;
            digit_valid <= state_n == SHOW;
            digit       <= state_n == SHOW ? seq[{idx_n, 2'b00} +: 4] : 4'd0;
            busy        <= state_n inside {LOAD, SHOW, GAP};
            done        <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_sequence_presenter.sv
// tb_sequence_presenter: randomized start/reset stimulus checked every cycle against a schedule-based model.
module tb_sequence_presenter;
    localparam int TD = 4, ST = 2, GT = 1;
    localparam logic [7:0] SEED = 8'hA5;
    localparam int SHOW_C = ST * TD, SLOT = (ST + GT) * TD, LAST = 4 + 4 * SLOT;

    logic clk = 0, reset = 1, start = 0;
    logic [3:0] digit;
    logic digit_valid, busy, done;
    logic [1:0] digit_idx;
    logic [15:0] seq;

    always #5 clk = ~clk;

    sequence_presenter #(.TICK_DIV(TD), .SHOW_TICKS(ST), .GAP_TICKS(GT), .SEED(SEED)) dut (
        .clk(clk), .reset(reset), .start(start), .digit(digit), .digit_valid(digit_valid),
        .digit_idx(digit_idx), .seq(seq), .busy(busy), .done(done)
    );

    int errors = 0, checks = 0;
    bit chk_en = 0;
    logic [7:0] m_lfsr;
    logic m_sd;
    logic [15:0] m_seq, s1_seq;
    int off;

    function automatic logic [7:0] step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [3:0] map(input logic [3:0] r);
        return r > 9 ? r - 4'd10 : r;
    endfunction

    // off = cycles since the accepted edge: 0 idle, 1..LAST busy, LAST+1 done
    always @(posedge clk) begin
        if (reset) begin
            m_lfsr <= SEED; m_sd <= 0; off <= 0; m_seq <= 0;
        end else begin
            if (off >= 1 && off <= 4) m_seq[(off-1)*4 +: 4] <= map(m_lfsr[3:0]);
            if (off >= 1 && off <= LAST) off <= off + 1;
            else if (start && !m_sd) off <= 1;
            m_lfsr <= step(m_lfsr);
            m_sd <= start;
        end
    end

    logic e_busy, e_done, e_valid, idx_chk, seq_chk;
    logic [3:0] e_digit;
    logic [1:0] e_idx;
    int p;

    always @(negedge clk) if (chk_en) begin
        e_busy = off >= 1 && off <= LAST;
        e_done = off == LAST + 1;
        e_valid = 0; e_digit = 0;
        e_idx = off == 0 ? 2'd0 : 2'd3;
        idx_chk = !(off >= 1 && off <= 4);
        seq_chk = idx_chk;
        if (off >= 5 && off <= LAST) begin
            p = (off - 5) / SLOT;
            e_idx = 2'(p);
            e_valid = ((off - 5) % SLOT) < SHOW_C;
            e_digit = e_valid ? m_seq[p*4 +: 4] : 4'd0;
        end
        checks++;
        if (busy !== e_busy || done !== e_done || digit_valid !== e_valid || digit !== e_digit ||
            (idx_chk && digit_idx !== e_idx) || (seq_chk && seq !== m_seq) || dut.lfsr !== m_lfsr) begin
            errors++;
            $display("FAIL cycle off=%0d actual/required: busy=%b/%b done=%b/%b valid=%b/%b digit=%0d/%0d idx=%0d/%0d seq=%h/%h lfsr=%h/%h",
                     off, busy, e_busy, done, e_done, digit_valid, e_valid, digit, e_digit,
                     digit_idx, e_idx, seq, m_seq, dut.lfsr, m_lfsr);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_pulse(input int i0, input int i1, input int i2);
        int nb, nv, nd;
        bit ok;
        nb = 0; nv = 0; nd = 0;
        start = 1;
        for (int n = 1; n <= 200 && nd == 0; n++) begin
            @(negedge clk);
            start = (n == i0 || n == i1 || n == i2);
            if (busy && nb == 0) nb = n;
            if (digit_valid && nv == 0) nv = n;
            if (done) nd = n;
        end
        start = 0;
        chk("busy_at", nb, 1);
        chk("valid_at", nv, 5);
        chk("done_at", nd, LAST + 1);
        ok = 1;
        for (int k = 0; k < 4; k++) if (seq[k*4 +: 4] > 9) ok = 0;
        chk("digits_in_range", int'(ok), 1);
    endtask

    initial begin
        reset = 1; start = 0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        reset = 0;
        repeat (20) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_seq", seq, 0);
        run_pulse(0, 0, 0);
        s1_seq = m_seq;
        repeat (5) @(negedge clk);
        run_pulse(2, 10, 30);
        // start held through reset release counts as an edge on the first free cycle
        start = 1; reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        repeat (100) @(negedge clk);
        chk("held_done", done, 1);
        chk("held_seq", seq, 16'h4050);
        chk("held_model_seq", m_seq, 16'h4050);
        chk("held_idx", digit_idx, 3);
        start = 0;
        repeat (10) @(negedge clk);
        chk("held_no_restart", busy, 0);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (19) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", digit_valid, 0);
        chk("midrst_seq", seq, 0);
        chk("midrst_done", done, 0);
        reset = 0;
        repeat (20) @(negedge clk);
        run_pulse(0, 0, 0);
        chk("reseed_seq", seq, s1_seq);
        for (int i = 0; i < 50; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run_pulse($urandom_range(2, 50), $urandom_range(2, 50), $urandom_range(2, 50));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
